// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : div_result_bcd
//  Description : Result stage behind the non-restoring divider. Captures
//                quotient, remainder and error flags on the divider's done
//                pulse, converts Q and R to packed BCD with a sequential
//                double-dabble (one iteration per clock, both operands in
//                parallel) and presents the result on a valid/ready
//                handshake. Results arriving while busy are dropped and
//                flagged on a one-cycle drop pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_result_bcd #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  input  logic                  done,
  input  logic [WIDTH-1:0]      Q,
  input  logic [WIDTH-1:0]      R,
  input  logic                  OV,
  input  logic                  DivByZero,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic [1:0]            err,
  output logic                  busy,
  output logic                  drop
);

  // Counter only has to reach WIDTH, so it never wraps.
  localparam int unsigned C_CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned C_BCD_W = 4 * DIGITS;
  // Count value during the final iteration; the counter lands on WIDTH.
  localparam logic [C_CNT_W-1:0] C_LAST_ITER = C_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  // Working registers: binary shift registers and BCD accumulators.
  logic [WIDTH-1:0]     r_q_bin;
  logic [WIDTH-1:0]     r_r_bin;
  logic [C_BCD_W-1:0]   r_q_acc;
  logic [C_BCD_W-1:0]   r_r_acc;
  logic [C_CNT_W-1:0]   r_cnt;

  // Result registers seen by the consumer.
  logic [C_BCD_W-1:0]   r_q_bcd;
  logic [C_BCD_W-1:0]   r_r_bcd;
  logic [1:0]           r_err;
  logic                 r_drop;

  logic [C_BCD_W-1:0]   w_q_step;
  logic [C_BCD_W-1:0]   w_r_step;
  logic                 w_last_iter;
  logic                 w_flag_err;

  // One double-dabble iteration: add 3 to each digit >= 5, then shift the
  // accumulator left by one taking the binary MSB into the LSB.
  function automatic logic [C_BCD_W-1:0] dabble_step(
    input logic [C_BCD_W-1:0] bcd,
    input logic               bin_msb
  );
    logic [C_BCD_W-1:0] adj;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = bcd[4*d +: 4];
      end
    end
    return {adj[C_BCD_W-2:0], bin_msb};
  endfunction

  assign w_q_step    = dabble_step(r_q_acc, r_q_bin[WIDTH-1]);
  assign w_r_step    = dabble_step(r_r_acc, r_r_bin[WIDTH-1]);
  assign w_last_iter = (r_cnt == C_LAST_ITER);
  assign w_flag_err  = OV | DivByZero;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: errored results skip conversion and go straight to HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (done) begin
          w_state_nxt = w_flag_err ? S_HOLD : S_CONV;
        end
      end
      S_CONV: begin
        if (w_last_iter) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture, iterate and load the result registers on entry to HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_bin <= '0;
      r_r_bin <= '0;
      r_q_acc <= '0;
      r_r_acc <= '0;
      r_cnt   <= '0;
      r_q_bcd <= '0;
      r_r_bcd <= '0;
      r_err   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (done) begin
            r_q_bin <= Q;
            r_r_bin <= R;
            r_q_acc <= '0;
            r_r_acc <= '0;
            r_cnt   <= '0;
            if (w_flag_err) begin
              r_q_bcd <= '0;
              r_r_bcd <= '0;
              r_err   <= {OV, DivByZero};
            end
          end
        end
        S_CONV: begin
          r_q_acc <= w_q_step;
          r_r_acc <= w_r_step;
          r_q_bin <= {r_q_bin[WIDTH-2:0], 1'b0};
          r_r_bin <= {r_r_bin[WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          if (w_last_iter) begin
            r_q_bcd <= w_q_step;
            r_r_bcd <= w_r_step;
            r_err   <= 2'b00;
          end
        end
        default: begin
          // HOLD: everything stays put until the handshake.
        end
      endcase
    end
  end

  // Flag a done that arrives while a result is in flight or waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= done && (r_state != S_IDLE);
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign q_bcd     = r_q_bcd;
  assign r_bcd     = r_r_bcd;
  assign err       = r_err;
  assign drop      = r_drop;

endmodule
`default_nettype wire
